// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Multi-cycle multiply/divide sequencer with the HI/LO register pair for the
// pipelined MIPS core. It lives in EX next to the ALU. A mult/multu/div/divu
// qualified by start is evaluated from the operands present at the start edge.
// The full 64-bit result is parked internally while the fixed latency is
// counted out. The result is then committed to HI/LO. mthi/mtlo write HI/LO
// directly in a single cycle. busy lets the hazard unit stall dependent
// md-class instructions in D.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   mdop   - operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//            6 mtlo, 7-15 none
//   start  - qualifies a mult/multu/div/divu mdop this cycle
//   a      - rs operand (forwarded)
//   b      - rt operand (forwarded)
//   busy   - operation in progress
//   hi     - HI register
//   lo     - LO register
// ---------------------------------------------------------------------------
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdop,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [63:0]       result, result_next;
  logic              div_zero, div_zero_next;
  logic [31:0]       hi_next, lo_next;

  // Arithmetic datapath signals
  logic [63:0] a_sext, b_sext, prod_s, prod_u;
  logic        div_signed;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, quot_mag, rem_mag;
  logic [31:0] quot, rem;

  // Multiply and divide results computed from the live operands. Only the
  // start edge captures them.
  always_comb begin
    a_sext = {{32{a[31]}}, a};
    b_sext = {{32{b[31]}}, b};
    // Low 64 bits of a 64x64 product of sign-extended operands equal the
    // signed 32x32 product.
    prod_s = a_sext * b_sext;
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes through the same unsigned divider.
    // Signs are fixed up afterwards. This keeps the -2^31 / -1 corner
    // well-defined (the quotient wraps to 0x80000000).
    div_signed = (mdop == OP_DIV);
    a_neg      = div_signed && a[31];
    b_neg      = div_signed && b[31];
    mag_a      = a_neg ? (32'd0 - a) : a;
    mag_b      = b_neg ? (32'd0 - b) : b;
    // A zero divisor is swapped for 1 so the divider never sees it. That
    // result is discarded at commit anyway.
    if (mag_b == 32'd0) begin
      mag_b = 32'd1;
    end
    quot_mag = mag_a / mag_b;
    rem_mag  = mag_a % mag_b;
    quot     = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
    rem      = a_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  // State register, countdown, parked result and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= CNT_ZERO;
      result   <= 64'd0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      result   <= result_next;
      div_zero <= div_zero_next;
      hi       <= hi_next;
      lo       <= lo_next;
    end
  end

  // Next-state logic. It accepts work only in IDLE. It counts down while busy
  // and commits on the edge where the counter reads 1.
  always_comb begin
    state_next    = state;
    count_next    = count;
    result_next   = result;
    div_zero_next = div_zero;
    hi_next       = hi;
    lo_next       = lo;

    case (state)
      IDLE: begin
        if (start && (mdop == OP_MULT || mdop == OP_MULTU)) begin
          state_next    = MUL;
          count_next    = MULT_LOAD;
          result_next   = (mdop == OP_MULT) ? prod_s : prod_u;
          div_zero_next = 1'b0;
        end else if (start && (mdop == OP_DIV || mdop == OP_DIVU)) begin
          state_next    = DIV;
          count_next    = DIV_LOAD;
          result_next   = {rem, quot};
          div_zero_next = (b == 32'd0);
        end else if (mdop == OP_MTHI) begin
          hi_next = a;
        end else if (mdop == OP_MTLO) begin
          lo_next = a;
        end
      end

      MUL, DIV: begin
        if (count == CNT_ONE) begin
          state_next = IDLE;
          count_next = CNT_ZERO;
          // A divide by zero still takes the full latency but leaves HI/LO alone.
          if (!div_zero) begin
            hi_next = result[63:32];
            lo_next = result[31:0];
          end
        end else begin
          count_next = count - CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = CNT_ZERO;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Directed testbench for md_sequencer with MULT_CYCLES=5 and DIV_CYCLES=10.
// Every expected HI/LO/busy value below was worked out by hand. Inputs are
// driven 1 time unit after the rising edge. Outputs are checked at the same
// point, just before the next stimulus is applied.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdop;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  md_sequencer #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mdop (mdop),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Advance to just past the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive the input bundle
  task automatic applyStimulus(input logic [3:0] op, input logic st,
                               input logic [31:0] va, input logic [31:0] vb);
    mdop  = op;
    start = st;
    a     = va;
    b     = vb;
  endtask

  // Compare busy/hi/lo against hand-computed values
  task automatic checkOutput(input string tag, input logic exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("[TB] FAIL %s busy: observed=%0b expected=%0b", tag, busy, exp_busy);
    end
    checks++;
    assert (hi === exp_hi) else begin
      errors++;
      $error("[TB] FAIL %s hi: observed=%08h expected=%08h", tag, hi, exp_hi);
    end
    checks++;
    assert (lo === exp_lo) else begin
      errors++;
      $error("[TB] FAIL %s lo: observed=%08h expected=%08h", tag, lo, exp_lo);
    end
  endtask

  // Start an operation. Scramble the operands straight after the start edge.
  // Expect busy for n cycles with HI/LO unchanged, then the new values once
  // busy drops.
  task automatic runOp(input string tag, input logic [3:0] op,
                       input logic [31:0] va, input logic [31:0] vb, input int n,
                       input logic [31:0] old_hi, input logic [31:0] old_lo,
                       input logic [31:0] new_hi, input logic [31:0] new_lo);
    applyStimulus(op, 1'b1, va, vb);
    tick;
    applyStimulus(4'd0, 1'b0, 32'h0BAD_F00D, 32'h0000_0007);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_busy%0d", tag, i), 1'b1, old_hi, old_lo);
      tick;
    end
    checkOutput($sformatf("%s_commit", tag), 1'b0, new_hi, new_lo);
  endtask

  initial begin
    $display("[TB] md_sequencer directed test");
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #10;
    checkOutput("reset", 1'b0, 32'h0, 32'h0);
    tick;
    reset = 1'b0;
    tick;
    checkOutput("post_reset", 1'b0, 32'h0, 32'h0);

    // Signed and unsigned multiply: 3 * 0xFFFFFFFE
    runOp("mult", 4'd1, 32'd3, 32'hFFFF_FFFE, 5,
          32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("multu", 4'd2, 32'd3, 32'hFFFF_FFFE, 5,
          32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);

    // Signed -7 / 2 = -3 rem -1; unsigned 7 / 2 = 3 rem 1
    runOp("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10,
          32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu", 4'd4, 32'd7, 32'd2, 10,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h1, 32'h3);

    // Moves, then divide by zero leaves HI/LO untouched
    applyStimulus(4'd5, 1'b0, 32'h0000_1234, 32'd0);
    tick;
    checkOutput("mthi", 1'b0, 32'h0000_1234, 32'h3);
    applyStimulus(4'd6, 1'b0, 32'h0000_5678, 32'd0);
    tick;
    checkOutput("mtlo", 1'b0, 32'h0000_1234, 32'h0000_5678);
    runOp("div0", 4'd3, 32'd100, 32'd0, 10,
          32'h0000_1234, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);

    // mult 5*6 with a div start, mthi and mtlo thrown at it while busy
    applyStimulus(4'd1, 1'b1, 32'd5, 32'd6);
    tick;
    applyStimulus(4'd3, 1'b1, 32'd100, 32'd3);
    checkOutput("ign_busy0", 1'b1, 32'h0000_1234, 32'h0000_5678);
    tick;
    applyStimulus(4'd5, 1'b0, 32'h0000_DEAD, 32'd0);
    checkOutput("ign_busy1", 1'b1, 32'h0000_1234, 32'h0000_5678);
    tick;
    applyStimulus(4'd6, 1'b0, 32'h0000_BEEF, 32'd0);
    checkOutput("ign_busy2", 1'b1, 32'h0000_1234, 32'h0000_5678);
    tick;
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("ign_busy3", 1'b1, 32'h0000_1234, 32'h0000_5678);
    tick;
    checkOutput("ign_busy4", 1'b1, 32'h0000_1234, 32'h0000_5678);
    tick;
    checkOutput("ign_commit", 1'b0, 32'h0, 32'h0000_001E);

    // Back-to-back start on the first idle cycle: multu 2*3
    runOp("b2b", 4'd2, 32'd2, 32'd3, 5,
          32'h0, 32'h0000_001E, 32'h0, 32'h6);

    // mthi in idle, then a reserved opcode with start does nothing
    applyStimulus(4'd5, 1'b0, 32'hAAAA_5555, 32'd0);
    tick;
    checkOutput("mthi2", 1'b0, 32'hAAAA_5555, 32'h6);
    applyStimulus(4'd9, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick;
    checkOutput("op9_a", 1'b0, 32'hAAAA_5555, 32'h6);
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
    tick;
    checkOutput("op9_b", 1'b0, 32'hAAAA_5555, 32'h6);

    // Reset two cycles into a mult: everything clears, no later commit
    applyStimulus(4'd1, 1'b1, 32'd3, 32'hFFFF_FFFE);
    tick;
    applyStimulus(4'd0, 1'b0, 32'd0, 32'd0);
    checkOutput("rst_mid_busy", 1'b1, 32'hAAAA_5555, 32'h6);
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid", 1'b0, 32'h0, 32'h0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      checkOutput($sformatf("rst_after%0d", i), 1'b0, 32'h0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
